if_stage: RTL

Instruction-fetch stage of the in-order single-issue RV32IM core. It owns the program counter and issues word fetches to instruction memory over a valid/ready request channel. It pairs in-order responses with their PCs in a small fetch buffer and presents `rv32_if_packet_t` to the operand-fetch stage through a valid/ready handshake. Redirects from execute (branches and jumps) flush the buffer and discard stale in-flight responses.

---
 rtl/rv32_pkg.sv | 16 +
 rtl/sync_fifo.sv | 57 +++++
 rtl/if_stage.sv | 115 +++++++++++
 3 files changed

// File: rtl/rv32_pkg.sv
// Shared types and constants for the RV32IM core: fetch-stage packet and
// instruction-memory request layout.
package rv32_pkg;

    localparam logic [31:0] RV32_RESET_PC = 32'h0000_0000;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instruction;
    } rv32_if_packet_t;

    typedef struct packed {
        logic [31:0] addr;
    } rv32_imem_req_t;

endpackage

// File: rtl/sync_fifo.sv
// Generic synchronous FIFO with flush; a push while full is taken only when
// a pop frees the slot in the same cycle.
module sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         i_push,
    input  logic [WIDTH-1:0]             i_data,
    input  logic                         i_pop,
    input  logic                         i_flush,
    output logic [WIDTH-1:0]             o_data,
    output logic                         o_full,
    output logic                         o_empty,
    output logic [$clog2(DEPTH+1)-1:0]   o_count
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             w_push;
    logic             w_pop;

    function automatic logic [PW-1:0] bump(input logic [PW-1:0] ptr);
        return (ptr == PW'(DEPTH - 1)) ? '0 : ptr + PW'(1);
    endfunction

    assign o_full  = (r_count == CW'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_count = r_count;
    assign o_data  = r_mem[r_rd_ptr];

    assign w_pop  = i_pop && !o_empty;
    assign w_push = i_push && (!o_full || w_pop);

    always_ff @(posedge clk) begin
        if (rst || i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= bump(r_wr_ptr);
            if (w_pop)  r_rd_ptr <= bump(r_rd_ptr);
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
        end
    end

    // NOTE: storage is deliberately not reset; r_count alone decides which slots hold data.
    always_ff @(posedge clk) begin
        if (w_push && !i_flush) r_mem[r_wr_ptr] <= i_data;
    end

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, issues credit-limited word fetches and
// pairs in-order responses with their PCs for the operand-fetch stage.
module if_stage
    import rv32_pkg::*;
#(
    parameter logic [31:0] RESET_PC    = RV32_RESET_PC,
    parameter int          FETCH_DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            redirect_valid,
    input  logic [31:0]     redirect_pc,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [31:0]     imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [31:0]     imem_rsp_data,
    output logic            if_valid,
    input  logic            if_ready,
    output rv32_if_packet_t if_packet
);
    localparam int CW = $clog2(FETCH_DEPTH + 1);

    logic [31:2]     r_pc;
    logic [CW-1:0]   r_inflight;
    logic [CW-1:0]   r_drop_cnt;

    rv32_imem_req_t  w_req;
    rv32_if_packet_t w_buf_in;
    logic [63:0]     w_buf_head;
    logic [31:0]     w_tag_pc;
    logic [CW-1:0]   w_tag_count;
    logic [CW-1:0]   w_buf_count;
    logic [CW:0]     w_credits_used;
    logic            w_tag_full, w_tag_empty, w_buf_full, w_buf_empty;
    logic            w_fire, w_rsp_drop, w_rsp_accept, w_buf_pop;
    logic            w_unused_lsbs;

    assign w_unused_lsbs = ^redirect_pc[1:0];

    assign w_req.addr     = {r_pc, 2'b00};
    assign imem_req_addr  = w_req.addr;
    assign w_credits_used = {1'b0, r_inflight} + {1'b0, w_buf_count};
    assign imem_req_valid = !rst && !redirect_valid && (w_credits_used < (CW+1)'(FETCH_DEPTH));
    assign w_fire         = imem_req_valid && imem_req_ready;

    // A response is discarded while stale ones are owed or when it lands on a redirect.
    assign w_rsp_drop   = imem_rsp_valid && (redirect_valid || r_drop_cnt != '0);
    assign w_rsp_accept = imem_rsp_valid && !w_rsp_drop;
    assign w_buf_in     = '{pc: w_tag_pc, instruction: imem_rsp_data};

    assign if_valid  = !w_buf_empty;
    assign if_packet = if_valid ? rv32_if_packet_t'(w_buf_head) : '0;
    assign w_buf_pop = if_valid && if_ready && !redirect_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc       <= RESET_PC[31:2];
            r_inflight <= '0;
            r_drop_cnt <= '0;
        end else begin
            if (redirect_valid) r_pc <= redirect_pc[31:2];
            else if (w_fire)    r_pc <= r_pc + 30'd1;

            case ({w_fire, imem_rsp_valid})
                2'b10:   r_inflight <= r_inflight + CW'(1);
                2'b01:   r_inflight <= r_inflight - CW'(1);
                default: r_inflight <= r_inflight;
            endcase

            // r_inflight already counts stale responses still owed, so everything
            // outstanding after this cycle becomes a drop.
            if (redirect_valid)
                r_drop_cnt <= r_inflight - CW'(imem_rsp_valid);
            else if (imem_rsp_valid && r_drop_cnt != '0)
                r_drop_cnt <= r_drop_cnt - CW'(1);
        end
    end

    sync_fifo #(.WIDTH(32), .DEPTH(FETCH_DEPTH)) u_tag_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_fire),
        .i_data  (w_req.addr),
        .i_pop   (w_rsp_accept),
        .i_flush (redirect_valid),
        .o_data  (w_tag_pc),
        .o_full  (w_tag_full),
        .o_empty (w_tag_empty),
        .o_count (w_tag_count)
    );

    sync_fifo #(.WIDTH(64), .DEPTH(FETCH_DEPTH)) u_fetch_buf (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_rsp_accept),
        .i_data  (w_buf_in),
        .i_pop   (w_buf_pop),
        .i_flush (redirect_valid),
        .o_data  (w_buf_head),
        .o_full  (w_buf_full),
        .o_empty (w_buf_empty),
        .o_count (w_buf_count)
    );

    a_buf_no_overflow: assert property (@(posedge clk) disable iff (rst)
        !(w_rsp_accept && w_buf_full && !w_buf_pop));
    a_tag_no_overflow: assert property (@(posedge clk) disable iff (rst)
        !(w_fire && w_tag_full));
    a_tag_present: assert property (@(posedge clk) disable iff (rst)
        !(w_rsp_accept && w_tag_empty));
    a_tag_balance: assert property (@(posedge clk) disable iff (rst)
        w_tag_count == r_inflight - r_drop_cnt);

endmodule
